// File: rtl/card_pkg.sv
// Shared card width, compare verdict codes and round FSM states
// for the card game round controller.
package card_pkg;

  localparam int CARD_W = 4;

  localparam logic [1:0] MR_INVALID = 2'b00;
  localparam logic [1:0] MR_DRAW    = 2'b01;
  localparam logic [1:0] MR_P1      = 2'b10;
  localparam logic [1:0] MR_P2      = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EVAL,
    ST_UPDATE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/card_latch.sv
// One player's card capture: valid/ready accept, card register,
// latched flag; the first card accepted is held until cleared.
module card_latch
  import card_pkg::*;
#(
  parameter int W = CARD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic         i_valid,
  input  logic [W-1:0] i_card,
  output logic         o_ready,
  output logic         o_latched,
  output logic [W-1:0] o_card
);

  logic         r_latched;
  logic [W-1:0] r_card;
  logic         w_take;

  assign o_ready   = i_en & ~r_latched;
  assign w_take    = i_valid & o_ready & ~i_clr;
  assign o_latched = r_latched;
  assign o_card    = r_card;

  // clear only drops the flag; the card stays visible to compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_latched <= 1'b0;
      r_card    <= '0;
    end else begin
      if (i_clr)       r_latched <= 1'b0;
      else if (w_take) r_latched <= 1'b1;
      if (w_take)      r_card    <= i_card;
    end
  end

endmodule

// File: rtl/round_scorer.sv
// Game-round controller: collects a card per player, samples the
// compare verdict, keeps scores and rounds, and declares a winner.
module round_scorer
  import card_pkg::*;
#(
  parameter int CARD_W     = card_pkg::CARD_W,
  parameter int NUM_ROUNDS = 5,
  parameter int WIN_SCORE  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              p1_valid,
  input  logic [CARD_W-1:0] p1_card,
  input  logic              p2_valid,
  input  logic [CARD_W-1:0] p2_card,
  input  logic [1:0]        matchresult,
  output logic [CARD_W-1:0] p1_handcard,
  output logic [CARD_W-1:0] p2_handcard,
  output logic              p1_ready,
  output logic              p2_ready,
  output logic [2:0]        p1_score,
  output logic [2:0]        p2_score,
  output logic [2:0]        round_cnt,
  output logic              round_done,
  output logic              game_over,
  output logic [1:0]        winner,
  output logic              err
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_mr;
  logic [2:0] r_p1;
  logic [2:0] r_p2;
  logic [2:0] r_cnt;

  logic       w_en;
  logic       w_clr;
  logic       w_lat1;
  logic       w_lat2;
  logic [2:0] w_p1_nxt;
  logic [2:0] w_p2_nxt;
  logic [2:0] w_cnt_nxt;
  logic       w_end;

  assign w_en  = (r_state == ST_COLLECT);
  assign w_clr = start | (r_state == ST_UPDATE);

  card_latch #(.W(CARD_W)) u_p1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_en),
    .i_clr     (w_clr),
    .i_valid   (p1_valid),
    .i_card    (p1_card),
    .o_ready   (p1_ready),
    .o_latched (w_lat1),
    .o_card    (p1_handcard)
  );

  card_latch #(.W(CARD_W)) u_p2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_en),
    .i_clr     (w_clr),
    .i_valid   (p2_valid),
    .i_card    (p2_card),
    .o_ready   (p2_ready),
    .o_latched (w_lat2),
    .o_card    (p2_handcard)
  );

  assign w_p1_nxt  = r_p1 + 3'(r_mr == MR_P1);
  assign w_p2_nxt  = r_p2 + 3'(r_mr == MR_P2);
  assign w_cnt_nxt = r_cnt + 3'd1;
  assign w_end     = (w_p1_nxt == 3'(WIN_SCORE))
                   | (w_p2_nxt == 3'(WIN_SCORE))
                   | (w_cnt_nxt == 3'(NUM_ROUNDS));

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = ST_COLLECT;
    end else begin
      unique case (r_state)
        ST_IDLE:    w_state_nxt = ST_IDLE;
        ST_COLLECT: if (w_lat1 & w_lat2) w_state_nxt = ST_EVAL;
        ST_EVAL:    w_state_nxt = ST_UPDATE;
        ST_UPDATE:  w_state_nxt = w_end ? ST_DONE : ST_COLLECT;
        ST_DONE:    w_state_nxt = ST_DONE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mr    <= MR_INVALID;
      r_p1    <= '0;
      r_p2    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (start) begin
        r_mr  <= MR_INVALID;
        r_p1  <= '0;
        r_p2  <= '0;
        r_cnt <= '0;
      end else begin
        if (r_state == ST_EVAL) r_mr <= matchresult;
        if (r_state == ST_UPDATE) begin
          r_p1  <= w_p1_nxt;
          r_p2  <= w_p2_nxt;
          r_cnt <= w_cnt_nxt;
        end
      end
    end
  end

  assign p1_score   = r_p1;
  assign p2_score   = r_p2;
  assign round_cnt  = r_cnt;
  assign round_done = (r_state == ST_UPDATE) & ~start;
  assign err        = round_done & (r_mr == MR_INVALID);
  assign game_over  = (r_state == ST_DONE);

  always_comb begin
    winner = MR_INVALID;
    if (game_over) begin
      unique case (1'b1)
        (r_p1 > r_p2): winner = MR_P1;
        (r_p2 > r_p1): winner = MR_P2;
        default:       winner = MR_DRAW;
      endcase
    end
  end

endmodule

// File: tb/tb_round_scorer.sv
// Randomized and directed bench for round_scorer with a
// behavioural compare and a game-level scoring model.
module tb_round_scorer;

  localparam int CW = 4;
  localparam int NR = 5;
  localparam int WS = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          p1_valid = 1'b0;
  logic [CW-1:0] p1_card = '0;
  logic          p2_valid = 1'b0;
  logic [CW-1:0] p2_card = '0;
  logic [1:0]    matchresult;
  logic [CW-1:0] p1_handcard;
  logic [CW-1:0] p2_handcard;
  logic          p1_ready;
  logic          p2_ready;
  logic [2:0]    p1_score;
  logic [2:0]    p2_score;
  logic [2:0]    round_cnt;
  logic          round_done;
  logic          game_over;
  logic [1:0]    winner;
  logic          err;
  logic          force_inv = 1'b0;

  int n_checks = 0;
  int n_err = 0;

  round_scorer #(
    .CARD_W(CW), .NUM_ROUNDS(NR), .WIN_SCORE(WS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .p1_valid(p1_valid), .p1_card(p1_card),
    .p2_valid(p2_valid), .p2_card(p2_card),
    .matchresult(matchresult),
    .p1_handcard(p1_handcard), .p2_handcard(p2_handcard),
    .p1_ready(p1_ready), .p2_ready(p2_ready),
    .p1_score(p1_score), .p2_score(p2_score),
    .round_cnt(round_cnt), .round_done(round_done),
    .game_over(game_over), .winner(winner), .err(err)
  );

  always #5 clk = ~clk;

  // behavioural compare stage
  always_comb begin
    if (force_inv)                      matchresult = 2'b00;
    else if (p1_handcard > p2_handcard) matchresult = 2'b10;
    else if (p2_handcard > p1_handcard) matchresult = 2'b11;
    else                                matchresult = 2'b01;
  end

  task automatic do_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: same cycle, 1: p1 first, 2: p2 first; junk is offered while not ready
  task automatic play_round(input logic [3:0] a, input logic [3:0] b,
                            input int mode, input logic [3:0] junk,
                            output int lat, output logic e);
    int k;
    lat = 0;
    e = 1'b0;
    k = 0;
    while (!(p1_ready && p2_ready) && k < 10) begin
      @(negedge clk);
      k++;
    end
    case (mode)
      0: begin
        p1_valid = 1'b1; p1_card = a;
        p2_valid = 1'b1; p2_card = b;
        @(negedge clk);
      end
      1: begin
        p1_valid = 1'b1; p1_card = a;
        @(negedge clk);
        p1_card = junk;
        @(negedge clk);
        p1_valid = 1'b0;
        p2_valid = 1'b1; p2_card = b;
        @(negedge clk);
      end
      default: begin
        p2_valid = 1'b1; p2_card = b;
        @(negedge clk);
        p2_card = junk;
        @(negedge clk);
        p2_valid = 1'b0;
        p1_valid = 1'b1; p1_card = a;
        @(negedge clk);
      end
    endcase
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (round_done) begin
        lat = i;
        e = err;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] outs;
    #1;
    outs = {p1_handcard, p2_handcard, p1_ready, p2_ready, p1_score,
            p2_score, round_cnt, round_done, game_over, winner, err};
    n_checks++;
    if (outs !== 32'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (p1_ready !== 1'b0) begin
      n_err++; $display("FAIL idle_ready: got %b want 0", p1_ready);
    end
    do_start();
    p1_valid = 1'b1; p1_card = 4'd9;
    @(negedge clk);
    p1_valid = 1'b0;
    n_checks++;
    if (p1_handcard !== 4'd9 || p1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL p1_latch: got card %0d ready %b want 9 0", p1_handcard, p1_ready);
    end
    rst_n = 1'b0;
    #1;
    outs = {p1_handcard, p2_handcard, p1_ready, p2_ready, p1_score,
            p2_score, round_cnt, round_done, game_over, winner, err};
    n_checks++;
    if (outs !== 32'd0) begin
      n_err++; $display("FAIL midreset_outputs: got %h want 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (p1_ready !== 1'b0 || p2_ready !== 1'b0) begin
      n_err++; $display("FAIL midreset_idle: ready %b%b want 00", p1_ready, p2_ready);
    end
    do_start();
    n_checks++;
    if (p1_ready !== 1'b1 || p1_handcard !== 4'd0) begin
      n_err++;
      $display("FAIL midreset_card: ready %b card %0d want 1 0", p1_ready, p1_handcard);
    end
  endtask

  task automatic test_same_cycle;
    int lat;
    logic e;
    do_start();
    play_round(4'd9, 4'd4, 0, 4'd0, lat, e);
    n_checks++;
    if (lat !== 3) begin
      n_err++; $display("FAIL same_latency: got %0d want 3", lat);
    end
    n_checks++;
    if (p1_score !== 3'd1 || p2_score !== 3'd0 || round_cnt !== 3'd1) begin
      n_err++;
      $display("FAIL same_score: got %0d/%0d cnt %0d want 1/0 cnt 1",
               p1_score, p2_score, round_cnt);
    end
    n_checks++;
    if (p1_handcard !== 4'd9 || p2_handcard !== 4'd4 || round_done !== 1'b0) begin
      n_err++;
      $display("FAIL same_hold: cards %0d %0d done %b want 9 4 0",
               p1_handcard, p2_handcard, round_done);
    end
  endtask

  task automatic test_ignored;
    int lat;
    logic e;
    do_start();
    play_round(4'd7, 4'd7, 1, 4'd2, lat, e);
    n_checks++;
    if (p1_handcard !== 4'd7) begin
      n_err++; $display("FAIL ignored_card: got %0d want 7", p1_handcard);
    end
    n_checks++;
    if (p1_score !== 3'd0 || p2_score !== 3'd0 || round_cnt !== 3'd1 || lat !== 3) begin
      n_err++;
      $display("FAIL ignored_draw: got %0d/%0d cnt %0d lat %0d want 0/0 cnt 1 lat 3",
               p1_score, p2_score, round_cnt, lat);
    end
  endtask

  task automatic test_p2_sweep;
    logic [3:0] ca [3] = '{4'd3, 4'd1, 4'd0};
    logic [3:0] cb [3] = '{4'd8, 4'd5, 4'd15};
    int lat;
    logic e;
    do_start();
    for (int i = 0; i < 3; i++) begin
      play_round(ca[i], cb[i], 2, 4'd6, lat, e);
      n_checks++;
      if (game_over !== (i == 2)) begin
        n_err++; $display("FAIL sweep_over r%0d: got %b want %b", i, game_over, i == 2);
      end
    end
    n_checks++;
    if (winner !== 2'b11 || p2_score !== 3'd3 || p1_score !== 3'd0 || round_cnt !== 3'd3) begin
      n_err++;
      $display("FAIL sweep_final: winner %b score %0d/%0d cnt %0d want 11 0/3 cnt 3",
               winner, p1_score, p2_score, round_cnt);
    end
    n_checks++;
    if (p1_ready !== 1'b0 || p2_ready !== 1'b0) begin
      n_err++; $display("FAIL sweep_ready: got %b%b want 00", p1_ready, p2_ready);
    end
  endtask

  task automatic test_five_rounds;
    logic [3:0] ca [5] = '{4'd9, 4'd1, 4'd5, 4'd12, 4'd4};
    logic [3:0] cb [5] = '{4'd2, 4'd6, 4'd5, 4'd3, 4'd11};
    int lat;
    logic e;
    do_start();
    for (int i = 0; i < 5; i++) begin
      play_round(ca[i], cb[i], i % 3, 4'd13, lat, e);
      n_checks++;
      if (game_over !== (i == 4)) begin
        n_err++; $display("FAIL five_over r%0d: got %b want %b", i, game_over, i == 4);
      end
    end
    n_checks++;
    if (winner !== 2'b01 || p1_score !== 3'd2 || p2_score !== 3'd2 || round_cnt !== 3'd5) begin
      n_err++;
      $display("FAIL five_final: winner %b score %0d/%0d cnt %0d want 01 2/2 cnt 5",
               winner, p1_score, p2_score, round_cnt);
    end
  endtask

  task automatic test_invalid;
    int lat;
    logic e;
    do_start();
    force_inv = 1'b1;
    play_round(4'd9, 4'd4, 0, 4'd0, lat, e);
    force_inv = 1'b0;
    n_checks++;
    if (e !== 1'b1 || err !== 1'b0) begin
      n_err++; $display("FAIL invalid_err: pulse %b after %b want 1 0", e, err);
    end
    n_checks++;
    if (p1_score !== 3'd0 || p2_score !== 3'd0 || round_cnt !== 3'd1) begin
      n_err++;
      $display("FAIL invalid_score: got %0d/%0d cnt %0d want 0/0 cnt 1",
               p1_score, p2_score, round_cnt);
    end
  endtask

  task automatic test_start_eval;
    int lat;
    int rd;
    logic e;
    do_start();
    play_round(4'd9, 4'd4, 0, 4'd0, lat, e);
    p1_valid = 1'b1; p1_card = 4'd2;
    p2_valid = 1'b1; p2_card = 4'd10;
    @(negedge clk);
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (p1_score !== 3'd0 || round_cnt !== 3'd0 || p1_ready !== 1'b1 || game_over !== 1'b0) begin
      n_err++;
      $display("FAIL eval_start_clear: p1 %0d cnt %0d ready %b over %b want 0 0 1 0",
               p1_score, round_cnt, p1_ready, game_over);
    end
    rd = 0;
    for (int i = 0; i < 4; i++) begin
      if (round_done) rd++;
      @(negedge clk);
    end
    n_checks++;
    if (rd !== 0 || p2_score !== 3'd0) begin
      n_err++; $display("FAIL eval_start_stale: done %0d p2 %0d want 0 0", rd, p2_score);
    end
  endtask

  task automatic test_random;
    int s1, s2, c, lat, mode, exp_w;
    logic e, inv, over;
    logic [3:0] a, b, junk;
    for (int g = 0; g < 20; g++) begin
      do_start();
      s1 = 0; s2 = 0; c = 0; over = 1'b0;
      while (!over) begin
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        junk = 4'($urandom_range(0, 15));
        mode = int'($urandom_range(0, 2));
        inv = ($urandom_range(0, 5) == 0);
        force_inv = inv;
        play_round(a, b, mode, junk, lat, e);
        force_inv = 1'b0;
        if (!inv && a > b) s1++;
        if (!inv && b > a) s2++;
        c++;
        over = (s1 == WS) || (s2 == WS) || (c == NR);
        exp_w = !over ? 0 : (s1 > s2) ? 2 : (s2 > s1) ? 3 : 1;
        n_checks++;
        if (lat !== 3 || e !== inv) begin
          n_err++;
          $display("FAIL rand_round g%0d: lat %0d err %b want 3 %b", g, lat, e, inv);
        end
        n_checks++;
        if (p1_score !== 3'(s1) || p2_score !== 3'(s2) || round_cnt !== 3'(c)) begin
          n_err++;
          $display("FAIL rand_score g%0d: got %0d/%0d cnt %0d want %0d/%0d cnt %0d",
                   g, p1_score, p2_score, round_cnt, s1, s2, c);
        end
        n_checks++;
        if (game_over !== over || winner !== 2'(exp_w)) begin
          n_err++;
          $display("FAIL rand_over g%0d: over %b winner %b want %b %0d",
                   g, game_over, winner, over, exp_w);
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_same_cycle();
    test_ignored();
    test_p2_sweep();
    test_five_rounds();
    test_invalid();
    test_start_eval();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
